// File: rtl/i2c_packet_master.sv
// I2C write master: sends {SLAVE_ADDR,W} followed by NUM_BYTES payload bytes.
// A NACK on the address or on any data byte ends the attempt with a STOP.
// The whole packet is then resent up to MAX_RETRY more times before the
// transaction is reported as failed.
module i2c_packet_master #(
    parameter int         CLK_DIV    = 250,
    parameter logic [6:0] SLAVE_ADDR = 7'h12,
    parameter int         NUM_BYTES  = 4,
    parameter int         MAX_RETRY  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send_trigger,
    input  logic [8*NUM_BYTES-1:0] tx_data,
    output logic                   SCL,
    inout  logic                   SDA,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic [3:0]             state_dbg
);

    localparam int         QW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int         IW        = $clog2(NUM_BYTES + 1);
    localparam logic [QW-1:0] QLAST  = QW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
    localparam logic [2:0] MAX_R     = 3'(MAX_RETRY);
    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_ADDR      = 3'd2,
        S_ADDR_ACK  = 3'd3,
        S_DATA      = 3'd4,
        S_DATA_ACK  = 3'd5,
        S_STOP      = 3'd6,
        S_RETRY_GAP = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [QW-1:0]          qcnt_q, qcnt_d;
    logic [1:0]             quarter_q, quarter_d;
    logic [2:0]             bit_q, bit_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [2:0]             retry_q, retry_d;
    logic                   fail_q, fail_d;
    logic [8*NUM_BYTES-1:0] payload_q, payload_d;
    logic                   done_q, done_d;
    logic                   nack_q, nack_d;
    logic [1:0]             sda_sync_q, sda_sync_d;

    logic                   quarter_end, slot_end, sda_in;
    logic [7:0]             cur_byte;
    logic                   scl_o, sda_low;

    assign quarter_end = (qcnt_q == QLAST);
    assign slot_end    = quarter_end && (quarter_q == 2'd3);
    assign sda_in      = sda_sync_q[1];

    // Select the payload byte addressed by idx_q (byte 0 is the MSB end)
    always_comb begin
        cur_byte = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IW'(i)) cur_byte = payload_q[8*(NUM_BYTES-1-i) +: 8];
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            quarter_q  <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            fail_q     <= 1'b0;
            payload_q  <= '0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            sda_sync_q <= '1;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            fail_q     <= fail_d;
            payload_q  <= payload_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    // Next-state and counter logic; all transitions happen at the end of a bit slot
    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        fail_d     = fail_q;
        payload_d  = payload_q;
        done_d     = 1'b0;
        nack_d     = 1'b0;
        sda_sync_d = {sda_sync_q[0], SDA};

        if (state_q != S_IDLE) begin
            if (quarter_end) begin
                qcnt_d    = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + QW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (send_trigger) begin
                    payload_d = tx_data;
                    retry_d   = '0;
                    fail_d    = 1'b0;
                    qcnt_d    = '0;
                    quarter_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (slot_end) begin
                    bit_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_DATA: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (slot_end) begin
                    if (!sda_in) begin
                        idx_d   = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_DATA_ACK: begin
                if (slot_end) begin
                    if (sda_in) begin
                        fail_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    if (!fail_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (retry_q < MAX_R) begin
                        retry_d = retry_q + 3'd1;
                        fail_d  = 1'b0;
                        state_d = S_RETRY_GAP;
                    end else begin
                        done_d  = 1'b1;
                        nack_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RETRY_GAP: begin
                if (slot_end) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus levels per state and quarter; SCL is high in q2,q3 of every clocked slot
    always_comb begin
        scl_o   = 1'b1;
        sda_low = 1'b0;
        unique case (state_q)
            S_START:                 sda_low = quarter_q[1];
            S_ADDR: begin
                scl_o   = quarter_q[1];
                sda_low = ~ADDR_BYTE[3'd7 - bit_q];
            end
            S_DATA: begin
                scl_o   = quarter_q[1];
                sda_low = ~cur_byte[3'd7 - bit_q];
            end
            S_ADDR_ACK, S_DATA_ACK:  scl_o = quarter_q[1];
            S_STOP: begin
                scl_o   = quarter_q[1];
                sda_low = (quarter_q != 2'd3);
            end
            default: ;
        endcase
    end

    assign SCL       = scl_o;
    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign nack_err  = nack_q;
    assign state_dbg = {1'b0, state_q};

endmodule

// File: tb/tb_i2c_packet_master.sv
// Directed bench: two masters (4-byte/2-retry and 1-byte/0-retry) each with a
// behavioural I2C slave that decodes START/STOP/bytes and ACKs per a policy.
module tb_i2c_packet_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: CLK_DIV=4, NUM_BYTES=4, MAX_RETRY=2
    logic        rst_a, trig_a, busy_a, done_a, nack_a, scl_a, drv_a;
    logic [31:0] txd_a;
    logic [3:0]  st_a;
    wire         sda_a;
    pullup (sda_a);
    assign sda_a = drv_a ? 1'b0 : 1'bz;

    // DUT B: CLK_DIV=4, NUM_BYTES=1, MAX_RETRY=0
    logic        rst_b, trig_b, busy_b, done_b, nack_b, scl_b, drv_b;
    logic [7:0]  txd_b;
    logic [3:0]  st_b;
    wire         sda_b;
    pullup (sda_b);
    assign sda_b = drv_b ? 1'b0 : 1'bz;

    i2c_packet_master #(.CLK_DIV(4), .SLAVE_ADDR(7'h12), .NUM_BYTES(4), .MAX_RETRY(2)) dut_a (
        .clk(clk), .reset(rst_a), .send_trigger(trig_a), .tx_data(txd_a), .SCL(scl_a),
        .SDA(sda_a), .busy(busy_a), .done(done_a), .nack_err(nack_a), .state_dbg(st_a));

    i2c_packet_master #(.CLK_DIV(4), .SLAVE_ADDR(7'h12), .NUM_BYTES(1), .MAX_RETRY(0)) dut_b (
        .clk(clk), .reset(rst_b), .send_trigger(trig_b), .tx_data(txd_b), .SCL(scl_b),
        .SDA(sda_b), .busy(busy_b), .done(done_b), .nack_err(nack_b), .state_dbg(st_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave/monitor state
    int          cyc = 0;
    int          mode_a = 0;
    logic        pscl_a = 1'b1, psda_a = 1'b1, inack_a = 1'b0;
    int          bc_a = 0, fb_a = 0;
    logic [7:0]  sh_a = '0;
    logic [7:0]  rx_a[$];
    int          starts_a, stops_a, gaps_a, dcnt_a, ncnt_a, start_cyc_a, done_cyc_a, idle_viol_a;
    logic        nack_at_done_a, busy_at_done_a;
    logic [3:0]  pst_a = '0;

    logic        pscl_b = 1'b1, psda_b = 1'b1, inack_b = 1'b0;
    int          bc_b = 0, fb_b = 0;
    int          starts_b, stops_b, gaps_b, dcnt_b, ncnt_b, start_cyc_b, done_cyc_b, idle_viol_b;
    logic        nack_at_done_b, busy_at_done_b;
    logic [3:0]  pst_b = '0;

    task automatic clr_stats();
        rx_a.delete();
        starts_a = 0; stops_a = 0; gaps_a = 0; dcnt_a = 0; ncnt_a = 0;
        start_cyc_a = -1; done_cyc_a = -1; nack_at_done_a = 1'b0; busy_at_done_a = 1'b0;
        starts_b = 0; stops_b = 0; gaps_b = 0; dcnt_b = 0; ncnt_b = 0;
        start_cyc_b = -1; done_cyc_b = -1; nack_at_done_b = 1'b0; busy_at_done_b = 1'b0;
    endtask

    // Bus decoding, ACK generation and event capture, sampled on the falling clk edge
    initial begin
        drv_a = 1'b0; drv_b = 1'b0; idle_viol_a = 0; idle_viol_b = 0;
        clr_stats();
        forever begin
            @(negedge clk);
            cyc++;
            // ---- slave A ----
            if (scl_a && pscl_a && psda_a && !sda_a) begin
                starts_a++; bc_a = 0; fb_a = 0; inack_a = 1'b0; drv_a = 1'b0;
            end else if (scl_a && pscl_a && !psda_a && sda_a) begin
                stops_a++;
            end else if (scl_a && !pscl_a) begin
                if (!inack_a) begin
                    sh_a = {sh_a[6:0], sda_a};
                    bc_a++;
                    if (bc_a == 8) rx_a.push_back(sh_a);
                end
            end else if (!scl_a && pscl_a) begin
                if (inack_a) begin
                    inack_a = 1'b0; drv_a = 1'b0; bc_a = 0; fb_a++;
                end else if (bc_a == 8) begin
                    inack_a = 1'b1;
                    case (mode_a)
                        1:       drv_a = (fb_a != 0);
                        2:       drv_a = !(fb_a == 3 && starts_a == 1);
                        default: drv_a = 1'b1;
                    endcase
                end
            end
            pscl_a = scl_a; psda_a = sda_a;
            if (st_a == 4'd1 && pst_a != 4'd1 && start_cyc_a < 0) start_cyc_a = cyc;
            if (st_a == 4'd7 && pst_a != 4'd7) gaps_a++;
            pst_a = st_a;
            if (done_a) begin
                dcnt_a++; done_cyc_a = cyc; nack_at_done_a = nack_a; busy_at_done_a = busy_a;
            end
            if (nack_a) ncnt_a++;
            if (!busy_a && !rst_a && (scl_a !== 1'b1 || sda_a !== 1'b1)) idle_viol_a++;
            // ---- slave B: ACK address, NACK the data byte ----
            if (scl_b && pscl_b && psda_b && !sda_b) begin
                starts_b++; bc_b = 0; fb_b = 0; inack_b = 1'b0; drv_b = 1'b0;
            end else if (scl_b && pscl_b && !psda_b && sda_b) begin
                stops_b++;
            end else if (scl_b && !pscl_b) begin
                if (!inack_b) bc_b++;
            end else if (!scl_b && pscl_b) begin
                if (inack_b) begin
                    inack_b = 1'b0; drv_b = 1'b0; bc_b = 0; fb_b++;
                end else if (bc_b == 8) begin
                    inack_b = 1'b1; drv_b = (fb_b == 0);
                end
            end
            pscl_b = scl_b; psda_b = sda_b;
            if (st_b == 4'd1 && pst_b != 4'd1 && start_cyc_b < 0) start_cyc_b = cyc;
            if (st_b == 4'd7 && pst_b != 4'd7) gaps_b++;
            pst_b = st_b;
            if (done_b) begin
                dcnt_b++; done_cyc_b = cyc; nack_at_done_b = nack_b; busy_at_done_b = busy_b;
            end
            if (nack_b) ncnt_b++;
            if (!busy_b && !rst_b && (scl_b !== 1'b1 || sda_b !== 1'b1)) idle_viol_b++;
        end
    end

    function automatic logic [63:0] rx_word(input int first, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (first + i < rx_a.size()) r = {r[55:0], rx_a[first + i]};
            else                         r = {r[55:0], 8'h00};
        end
        return r;
    endfunction

    task automatic pulse_a(input logic [31:0] d);
        @(negedge clk); txd_a = d; trig_a = 1'b1;
        @(negedge clk); trig_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int d0 = dcnt_a;
        int n  = 0;
        while (dcnt_a == d0 && n < 4000) begin @(posedge clk); n++; end
        if (dcnt_a == d0) check_val({tag, " timeout"}, 64'd0, 64'd1);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        rst_a = 1'b1; trig_a = 1'b0; txd_a = '0;
        rst_b = 1'b1; trig_b = 1'b0; txd_b = '0;
        repeat (3) @(negedge clk);
        check_val("reset SCL", 64'(scl_a), 64'd1);
        check_val("reset SDA", 64'(sda_a), 64'd1);
        check_val("reset busy/done/nack", {61'd0, busy_a, done_a, nack_a}, 64'd0);
        check_val("reset state_dbg", 64'(st_a), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (5) @(posedge clk);

        // 1: plain write, all ACKed
        clr_stats(); mode_a = 0;
        pulse_a(32'h012C_1400);
        wait_done_a("t1");
        check_val("t1 bytes", rx_word(0, 5), 64'h24_012C_1400);
        check_val("t1 byte count", 64'(rx_a.size()), 64'd5);
        check_val("t1 start/stop", {32'(starts_a), 32'(stops_a)}, {32'd1, 32'd1});
        check_val("t1 latency", 64'(done_cyc_a - start_cyc_a), 64'd752);
        check_val("t1 done/nack pulses", {32'(dcnt_a), 32'(ncnt_a)}, {32'd1, 32'd0});
        check_val("t1 busy at done", 64'(busy_at_done_a), 64'd0);

        // 2: address NACK on every attempt
        clr_stats(); mode_a = 1;
        pulse_a(32'h0102_0304);
        wait_done_a("t2");
        check_val("t2 start/stop", {32'(starts_a), 32'(stops_a)}, {32'd3, 32'd3});
        check_val("t2 retry gaps", 64'(gaps_a), 64'd2);
        check_val("t2 nack with done", {62'd0, nack_at_done_a, busy_at_done_a}, 64'd2);
        check_val("t2 done/nack pulses", {32'(dcnt_a), 32'(ncnt_a)}, {32'd1, 32'd1});
        check_val("t2 bytes", rx_word(0, 3), 64'h24_2424);
        check_val("t2 latency", 64'(done_cyc_a - start_cyc_a), 64'd560);

        // 3: NACK on data byte 2 of the first attempt only
        clr_stats(); mode_a = 2;
        pulse_a(32'hA5C3_0FF0);
        wait_done_a("t3");
        check_val("t3 first attempt", rx_word(0, 4), 64'h24A5_C30F);
        check_val("t3 resend", rx_word(4, 5), 64'h24_A5C3_0FF0);
        check_val("t3 byte count", 64'(rx_a.size()), 64'd9);
        check_val("t3 starts/gaps", {32'(starts_a), 32'(gaps_a)}, {32'd2, 32'd1});
        check_val("t3 nack pulses", 64'(ncnt_a), 64'd0);
        check_val("t3 latency", 64'(done_cyc_a - start_cyc_a), 64'd1376);

        // 4: re-trigger while busy is ignored
        clr_stats(); mode_a = 0;
        pulse_a(32'h1122_3344);
        repeat (200) @(posedge clk);
        pulse_a(32'hDEAD_BEEF);
        wait_done_a("t4");
        repeat (40) @(posedge clk);
        check_val("t4 bytes", rx_word(0, 5), 64'h24_1122_3344);
        check_val("t4 byte count", 64'(rx_a.size()), 64'd5);
        check_val("t4 done pulses", 64'(dcnt_a), 64'd1);
        check_val("t4 latency", 64'(done_cyc_a - start_cyc_a), 64'd752);

        // 5: reset during DATA bit 3, then a clean transaction
        clr_stats(); mode_a = 0;
        pulse_a(32'h5555_AAAA);
        begin
            int n = 0;
            while (st_a != 4'd4 && n < 1000) begin @(posedge clk); n++; end
            check_val("t5 reach DATA", 64'(st_a), 64'd4);
        end
        repeat (56) @(posedge clk);
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk);
        check_val("t5 abort SCL/SDA", {62'd0, scl_a, sda_a}, 64'd3);
        check_val("t5 abort state/busy", {59'd0, st_a, busy_a}, 64'd0);
        rst_a = 1'b0;
        check_val("t5 no done on abort", 64'(dcnt_a), 64'd0);
        repeat (5) @(posedge clk);
        clr_stats();
        pulse_a(32'hCAFE_0001);
        wait_done_a("t5b");
        check_val("t5 bytes", rx_word(0, 5), 64'h24_CAFE_0001);
        check_val("t5 latency", 64'(done_cyc_a - start_cyc_a), 64'd752);
        check_val("t5 nack pulses", 64'(ncnt_a), 64'd0);

        // 6: single byte, no retries, data NACK
        clr_stats();
        @(negedge clk); txd_b = 8'h5A; trig_b = 1'b1;
        @(negedge clk); trig_b = 1'b0;
        begin
            int n = 0;
            while (dcnt_b == 0 && n < 4000) begin @(posedge clk); n++; end
            if (dcnt_b == 0) check_val("t6 timeout", 64'd0, 64'd1);
        end
        repeat (40) @(posedge clk);
        check_val("t6 start/stop", {32'(starts_b), 32'(stops_b)}, {32'd1, 32'd1});
        check_val("t6 no retry gap", 64'(gaps_b), 64'd0);
        check_val("t6 done/nack pulses", {32'(dcnt_b), 32'(ncnt_b)}, {32'd1, 32'd1});
        check_val("t6 nack with done", {62'd0, nack_at_done_b, busy_at_done_b}, 64'd2);
        check_val("t6 latency", 64'(done_cyc_b - start_cyc_b), 64'd320);

        check_val("idle bus A", 64'(idle_viol_a), 64'd0);
        check_val("idle bus B", 64'(idle_viol_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
